// File: rtl/otn_pkg.sv
// Constants and state encodings shared by the OTN frame sender and receiver.
package otn_pkg;

    localparam int unsigned FRAME_BYTES = 4165;
    localparam int unsigned FAS_BYTES   = 6;
    localparam int unsigned FAS_LEN     = 48;
    localparam logic [47:0] FAS_PATTERN = 48'h282828F6F6F6;
    localparam int unsigned BYTE_CNT_W  = 13;

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } rx_state_e;

    typedef enum logic [1:0] {
        A_IDLE  = 2'd0,
        A_START = 2'd1,
        A_BIT   = 2'd2,
        A_STOP  = 2'd3
    } ack_state_e;

endpackage

// File: rtl/ack_ser.sv
// Serial ACK return: start (low), good flag, stop (low), each held for
// ACK_SYM_LEN baud enables; the line idles high.
//
// state   | meaning
// A_IDLE  | line high, waiting for a request
// A_START | start symbol, line low
// A_BIT   | ACK symbol, line = latched good flag
// A_STOP  | stop symbol, line low
module ack_ser
    import otn_pkg::*;
#(
    parameter int unsigned ACK_SYM_LEN = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req,
    input  logic i_good,
    input  logic i_sclk_en_16_x_baud,
    output logic o_otn_tx_ack
);

    localparam int unsigned CW = (ACK_SYM_LEN > 1) ? $clog2(ACK_SYM_LEN) : 1;
    localparam logic [CW-1:0] SYM_LAST = CW'(ACK_SYM_LEN - 1);

    ack_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          good_q, good_d;
    logic          ack_q, ack_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= A_IDLE;
            cnt_q   <= '0;
            good_q  <= 1'b0;
            ack_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            good_q  <= good_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        good_d  = good_q;
        ack_d   = 1'b1;
        if (state_q == A_IDLE) begin
            // Requests outside A_IDLE are dropped by construction.
            if (i_req) begin
                state_d = A_START;
                cnt_d   = SYM_LAST;
                good_d  = i_good;
            end
        end else if (i_sclk_en_16_x_baud) begin
            if (cnt_q == '0) begin
                cnt_d = SYM_LAST;
                case (state_q)
                    A_START: state_d = A_BIT;
                    A_BIT:   state_d = A_STOP;
                    default: state_d = A_IDLE;
                endcase
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
        case (state_d)
            A_START: ack_d = 1'b0;
            A_BIT:   ack_d = good_d;
            A_STOP:  ack_d = 1'b0;
            default: ack_d = 1'b1;
        endcase
    end

    assign o_otn_tx_ack = ack_q;

endmodule

// File: rtl/otn_frame_rec.sv
// OTN frame receiver: 16x oversampled bit recovery, FAS hunt, LSB-first
// byte assembly, trailing BIP-8 check and serial ACK return.
//
// state | meaning
// HUNT  | sliding 48-bit window compared against the FAS on every sample
// RECV  | assembling bytes FAS_BYTES..FRAME_BYTES-1; the last one is BIP-8
module otn_frame_rec
    import otn_pkg::*;
#(
    parameter int unsigned FRAME_BYTES  = otn_pkg::FRAME_BYTES,
    parameter logic [47:0] FAS_PATTERN  = otn_pkg::FAS_PATTERN,
    parameter int unsigned SAMPLE_PHASE = 7,
    parameter int unsigned ACK_SYM_LEN  = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sclk_en_16_x_baud,
    input  logic       i_otn_rx_data,
    input  logic       i_arq_en,
    output logic       o_otn_tx_ack,
    output logic [7:0] o_rx_data,
    output logic       o_rx_data_valid,
    output logic       o_rx_fas,
    output logic       o_frame_done,
    output logic       o_frame_good,
    output logic       o_locked
);

    localparam int unsigned BW = BYTE_CNT_W;
    localparam logic [BW-1:0] LAST_BYTE     = BW'(FRAME_BYTES - 1);
    localparam logic [BW-1:0] FIRST_PAYLOAD = BW'(FAS_BYTES);
    localparam logic [3:0]    SAMPLE_PH     = 4'(SAMPLE_PHASE);

    logic [1:0]         sync_q;
    logic               dly_q;
    logic [3:0]         phase_q, phase_d;
    logic [FAS_LEN-1:0] sr_q, sr_d, sr_shift;
    rx_state_e          state_q, state_d;
    logic [BW-1:0]      byte_cnt_q, byte_cnt_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         bip_q, bip_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic               fas_q, fas_d;
    logic               done_q, done_d;
    logic               good_q, good_d;
    logic               rx_edge, sample;
    logic [7:0]         rx_byte;

    assign rx_edge  = sync_q[1] ^ dly_q;
    assign sample   = i_sclk_en_16_x_baud && (phase_q == SAMPLE_PH);
    assign sr_shift = {sync_q[1], sr_q[FAS_LEN-1:1]};
    // The last eight samples, already in LSB-first byte order.
    assign rx_byte  = sr_shift[FAS_LEN-1 -: 8];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q     <= 2'b11;
            dly_q      <= 1'b1;
            phase_q    <= '0;
            sr_q       <= '1;
            state_q    <= HUNT;
            byte_cnt_q <= '0;
            bit_cnt_q  <= '0;
            bip_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            fas_q      <= 1'b0;
            done_q     <= 1'b0;
            good_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], i_otn_rx_data};
            dly_q      <= sync_q[1];
            phase_q    <= phase_d;
            sr_q       <= sr_d;
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            bip_q      <= bip_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            fas_q      <= fas_d;
            done_q     <= done_d;
            good_q     <= good_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        if (rx_edge) begin
            phase_d = '0;
        end else if (i_sclk_en_16_x_baud) begin
            phase_d = phase_q + 4'd1;
        end
    end

    always_comb begin
        sr_d       = sample ? sr_shift : sr_q;
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        bip_d      = bip_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        fas_d      = 1'b0;
        done_d     = 1'b0;
        good_d     = 1'b0;
        if (sample) begin
            case (state_q)
                HUNT: begin
                    if (sr_shift == FAS_PATTERN) begin
                        fas_d      = 1'b1;
                        byte_cnt_d = FIRST_PAYLOAD;
                        bit_cnt_d  = '0;
                        bip_d      = '0;
                        state_d    = RECV;
                    end
                end
                default: begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (byte_cnt_q < LAST_BYTE) begin
                            data_d     = rx_byte;
                            valid_d    = 1'b1;
                            bip_d      = bip_q ^ rx_byte;
                            byte_cnt_d = byte_cnt_q + BW'(1);
                        end else begin
                            // Flush the window so the next FAS needs a full 48 fresh bits.
                            done_d  = 1'b1;
                            good_d  = (rx_byte == bip_q);
                            state_d = HUNT;
                            sr_d    = '1;
                        end
                    end
                end
            endcase
        end
    end

    ack_ser #(
        .ACK_SYM_LEN(ACK_SYM_LEN)
    ) u_ack_ser (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_req               (done_q & i_arq_en),
        .i_good              (good_q),
        .i_sclk_en_16_x_baud (i_sclk_en_16_x_baud),
        .o_otn_tx_ack        (o_otn_tx_ack)
    );

    assign o_rx_data       = data_q;
    assign o_rx_data_valid = valid_q;
    assign o_rx_fas        = fas_q;
    assign o_frame_done    = done_q;
    assign o_frame_good    = good_q;
    assign o_locked        = (state_q == RECV);

endmodule

// File: doc/otn_frame_rec.md
Name: otn_frame_rec

Overview:
Receive-side partner of the sender's transmit/retransmit block. It deserialises the OTN line bit stream, using the same 16x-baud enable and LSB-first, 16-enables-per-bit format the sender emits. It hunts for the 48-bit FAS, assembles each frame into bytes and streams the payload downstream. It checks a trailing BIP-8 byte and, when ARQ is enabled, returns the serial ACK sequence (start low, ACK bit with 1 = good, stop low) that the sender waits on.

Parameters:
FRAME_BYTES, 4165, total bytes per frame: FAS, then payload, then BIP byte.
FAS_PATTERN, 48'h282828F6F6F6, FAS as received; bits [7:0] are the first byte on the line.
SAMPLE_PHASE, 7, phase count (0-15) at which a bit is sampled.
ACK_SYM_LEN, 16, i_sclk_en_16_x_baud pulses per ACK symbol.

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, asynchronous, active-high
i_sclk_en_16_x_baud  in  1  one-cycle enable at 16x baud
i_otn_rx_data  in  1  serial frame stream from the sender (asynchronous to i_clk)
i_arq_en  in  1  ARQ switch; 1 = ACK returned after every frame
o_otn_tx_ack  out  1  serial ACK line to the sender; idles high
o_rx_data  out  8  payload byte
o_rx_data_valid  out  1  one-cycle strobe with o_rx_data
o_rx_fas  out  1  one-cycle pulse when FAS is matched
o_frame_done  out  1  one-cycle pulse after the BIP byte is received
o_frame_good  out  1  valid with o_frame_done; 1 = BIP matched
o_locked  out  1  high while in the RECV state

Behaviour:
- Reset values (asynchronous, all registers): o_otn_tx_ack=1; all other outputs 0; state HUNT; counters 0; shift register all ones.
- Input synchroniser: i_otn_rx_data passes through a 2-flop synchroniser. An edge is a difference between sync[1] and a third delay flop.
- Phase counter: 4-bit, increments on each enable and wraps 15->0. It is cleared to 0 on any detected edge; an edge takes priority over the increment.
- Sample strobe: enable AND phase==SAMPLE_PHASE, giving one sample per bit period.
- Shift register: 48-bit. On each sample it shifts right, inserting the sample at bit 47.
- FSM, state HUNT:
  - On a sample, compare the post-shift register to FAS_PATTERN.
  - On a match: pulse o_rx_fas; set byte_cnt=6, bit_cnt=0, bip=0; go to RECV.
- FSM, state RECV:
  - Samples accumulate LSB-first into a byte; bit_cnt counts 0-7.
  - On bit 7: if byte_cnt < FRAME_BYTES-1, output the byte with o_rx_data_valid (1-cycle latency from the sample), set bip ^= byte, and increment byte_cnt.
  - On the byte at index FRAME_BYTES-1: pulse o_frame_done with o_frame_good = (byte == bip). Return to HUNT and reset the shift register to all ones.
- BIP-8 is the XOR of bytes 6..FRAME_BYTES-2; FAS bytes are excluded.
- byte_cnt is 13 bits and never wraps (maximum 4164).
- ACK request: o_frame_done with i_arq_en=1. i_arq_en is sampled on the o_frame_done cycle only.
- ACK sender FSM states and levels:
  - A_IDLE: line high.
  - A_START: line low.
  - A_BIT: line = good flag.
  - A_STOP: line low.
  - Then back to A_IDLE.
- Each ACK symbol is held for ACK_SYM_LEN enables. The first symbol begins on the cycle after the request.
- An ACK request while the ACK FSM is not in A_IDLE is dropped; the in-progress sequence completes unchanged.
- Receiver hunting continues in parallel with the ACK sequence.
- With i_arq_en=0 the ACK line stays high.
- Reset mid-frame or mid-ACK: everything returns to reset values immediately. Partial frames produce no o_frame_done.

Decomposition:
- Shared package (otn_pkg): FRAME_BYTES, FAS length/pattern constants, the receive FSM encodings (HUNT, RECV) and the ACK FSM encodings (A_IDLE, A_START, A_BIT, A_STOP). FRAME_BYTES is also used by the sender.
- One sub-module, ack_ser: the ACK FSM plus its symbol counter. Inputs are the request, the good flag and the enable; output is o_otn_tx_ack.

Test Plan:
- Clean frame: FAS, payload bytes 0x00..0xFF repeating, correct BIP; arq_en=1.
  - Expect 4158 payload strobes with matching data, o_frame_good=1.
  - Expect o_otn_tx_ack low 16 enables, high 16, low 16, then high.
- Corrupt one payload bit: o_frame_good=0 and the ACK bit symbol is low for 16 enables.
- Partial FAS: send F6F6F628 2800 then random data. Expect no lock and no strobes; a following true FAS locks within 48 bit times.
- arq_en=0 with a clean frame: o_frame_done=1, o_frame_good=1, o_otn_tx_ack constantly 1.
- Phase offset: stream delayed 5 enables relative to the counter. Expect a correct lock and frame; each sample falls 7 enables after the bit edge.
- Reset asserted at byte 2000 mid-frame: outputs return to reset values at once. Next frame is received and reported good; no spurious o_frame_done.
